// File: rtl/wf_blink_code_tx_pkg.sv
// Shared types and defaults for the blink-code transmitter.
// State encoding and default phase lengths, counted in tick_en pulses.
package wf_blink_code_tx_pkg;

    localparam int unsigned TIMER_W = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ON   = 3'd1,
        S_OFF  = 3'd2,
        S_LONG = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam int unsigned DEF_ON_TICKS   = 2;
    localparam int unsigned DEF_OFF_TICKS  = 2;
    localparam int unsigned DEF_GAP_TICKS  = 4;
    localparam int unsigned DEF_LONG_TICKS = 6;

endpackage

// File: rtl/wf_phase_timer.sv
// Phase timer: counts tick_en pulses since the last clear and flags the len-th one.
// expire is combinational so the owning FSM can leave the phase on that same edge.
module wf_phase_timer
    import wf_blink_code_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               tick_en,
    input  logic [TIMER_W-1:0] len,
    output logic               expire
);

    logic [TIMER_W-1:0] cnt;

    assign expire = tick_en && (cnt == len - TIMER_W'(1));

    // A clear in the transition cycle swallows that cycle's tick for the next phase.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (tick_en) begin
            cnt <= cnt + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/wf_blink_code_tx.sv
// Sends a 4-bit code as LED flashes: N short flashes, or one long flash for 0, then a gap.
// Define WF_BLINK_REPEAT_EN to replay the stored code forever instead of returning to idle.
module wf_blink_code_tx
    import wf_blink_code_tx_pkg::*;
#(
    parameter int unsigned ON_TICKS   = DEF_ON_TICKS,
    parameter int unsigned OFF_TICKS  = DEF_OFF_TICKS,
    parameter int unsigned GAP_TICKS  = DEF_GAP_TICKS,
    parameter int unsigned LONG_TICKS = DEF_LONG_TICKS,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_en,
    input  logic       code_valid,
    input  logic [3:0] code_in,
    output logic       code_ready,
    output logic       led_out,
    output logic       busy,
    output logic       done
);

    localparam logic [TIMER_W-1:0] ON_LEN   = TIMER_W'(ON_TICKS);
    localparam logic [TIMER_W-1:0] OFF_LEN  = TIMER_W'(OFF_TICKS);
    localparam logic [TIMER_W-1:0] GAP_LEN  = TIMER_W'(GAP_TICKS);
    localparam logic [TIMER_W-1:0] LONG_LEN = TIMER_W'(LONG_TICKS);
    localparam logic LED_ON  = !ACTIVE_LOW;
    localparam logic LED_OFF = ACTIVE_LOW;
`ifdef WF_BLINK_REPEAT_EN
    localparam logic GAP_READY = 1'b1;
`else
    localparam logic GAP_READY = 1'b0;
`endif

    state_t             state;
    logic [3:0]         remaining;
    logic [TIMER_W-1:0] phase_len;
    logic               phase_clear;
    logic               expire;

`ifdef WF_BLINK_REPEAT_EN
    logic [3:0] code_q;
    logic [3:0] next_code;

    // A code accepted in the expiring gap cycle already drives the next frame.
    assign next_code = code_valid ? code_in : code_q;
`endif

    always_comb begin
        phase_len = ON_LEN;
        unique case (state)
            S_ON:    phase_len = ON_LEN;
            S_OFF:   phase_len = OFF_LEN;
            S_LONG:  phase_len = LONG_LEN;
            S_GAP:   phase_len = GAP_LEN;
            default: phase_len = ON_LEN;
        endcase
    end

    assign phase_clear = (state == S_IDLE) || expire;

    wf_phase_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (phase_clear),
        .tick_en (tick_en),
        .len     (phase_len),
        .expire  (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            remaining  <= 4'd0;
            led_out    <= LED_OFF;
            code_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef WF_BLINK_REPEAT_EN
            code_q     <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (code_valid) begin
                        state      <= (code_in != 4'd0) ? S_ON : S_LONG;
                        remaining  <= code_in;
                        led_out    <= LED_ON;
                        code_ready <= 1'b0;
                        busy       <= 1'b1;
`ifdef WF_BLINK_REPEAT_EN
                        code_q     <= code_in;
`endif
                    end
                end
                S_ON: begin
                    if (expire) begin
                        remaining <= remaining - 4'd1;
                        led_out   <= LED_OFF;
                        if (remaining == 4'd1) begin
                            state      <= S_GAP;
                            code_ready <= GAP_READY;
                        end else begin
                            state <= S_OFF;
                        end
                    end
                end
                S_OFF: begin
                    if (expire) begin
                        state   <= S_ON;
                        led_out <= LED_ON;
                    end
                end
                S_LONG: begin
                    if (expire) begin
                        state      <= S_GAP;
                        led_out    <= LED_OFF;
                        code_ready <= GAP_READY;
                    end
                end
                S_GAP: begin
`ifdef WF_BLINK_REPEAT_EN
                    if (code_valid) begin
                        code_q <= code_in;
                    end
                    if (expire) begin
                        state      <= (next_code != 4'd0) ? S_ON : S_LONG;
                        remaining  <= next_code;
                        led_out    <= LED_ON;
                        code_ready <= 1'b0;
                        done       <= 1'b1;
                    end
`else
                    if (expire) begin
                        state      <= S_IDLE;
                        code_ready <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
`endif
                end
                default: begin
                    state      <= S_IDLE;
                    led_out    <= LED_OFF;
                    code_ready <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wf_blink_code_tx.sv
// Bench for wf_blink_code_tx: table of frames, random frames, abort and handshake corners.
// Expected LED shape comes from a (lit, ticks) segment list built from the code.
module tb_wf_blink_code_tx;

    localparam int ON_T   = 2;
    localparam int OFF_T  = 2;
    localparam int GAP_T  = 4;
    localparam int LONG_T = 6;
    localparam bit ACT_LO = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_en;
    logic       code_valid;
    logic [3:0] code_in;
    logic       code_ready;
    logic       led_out;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    int tick_mode = 0;   // 0: every 4 clocks, 1: stuck high, 2: random
    int tick_phase = 0;
    int exp_lv[$];
    int exp_tk[$];

    always #5 clk = ~clk;

    wf_blink_code_tx #(
        .ON_TICKS   (ON_T),
        .OFF_TICKS  (OFF_T),
        .GAP_TICKS  (GAP_T),
        .LONG_TICKS (LONG_T),
        .ACTIVE_LOW (ACT_LO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_en    (tick_en),
        .code_valid (code_valid),
        .code_in    (code_in),
        .code_ready (code_ready),
        .led_out    (led_out),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int code;
        int mode;
        int exp_flashes;
        int exp_clocks;   // 0 = not checked
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lit();
        return int'(led_out ^ ACT_LO);
    endfunction

    // Advance to the next negedge and choose tick_en for the cycle that follows.
    task automatic step();
        @(negedge clk);
        case (tick_mode)
            0: begin
                tick_en = (tick_phase == 3);
                tick_phase = (tick_phase + 1) % 4;
            end
            1: tick_en = 1'b1;
            default: tick_en = ($urandom_range(0, 2) == 0);
        endcase
    endtask

    function automatic void model(input int code);
        exp_lv.delete();
        exp_tk.delete();
        if (code == 0) begin
            exp_lv.push_back(1); exp_tk.push_back(LONG_T);
        end else begin
            for (int i = 1; i <= code; i++) begin
                exp_lv.push_back(1); exp_tk.push_back(ON_T);
                if (i < code) begin
                    exp_lv.push_back(0); exp_tk.push_back(OFF_T);
                end
            end
        end
        exp_lv.push_back(0); exp_tk.push_back(GAP_T);
    endfunction

`ifndef WF_BLINK_REPEAT_EN
    // Send one code, record (lit, ticks) runs until done, compare with the model.
    task automatic run_frame(input string tag, input int code, input int inject_flash,
                             output int flashes, output int clocks);
        int lv[$];
        int tk[$];
        int cur;
        int cnt;
        int ready_hi;
        int busy_lo;
        int lit_starts;
        bit got_done;
        step();
        check({tag, " ready_before"}, int'(code_ready), 1);
        code_valid = 1'b1;
        code_in = 4'(code);
        step();
        code_valid = 1'b0;
        cur = -1; cnt = 0; ready_hi = 0; busy_lo = 0; lit_starts = 0;
        got_done = 1'b0; clocks = 0; flashes = 0;
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            if (cyc > 0) step();
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (lit() != cur) begin
                    if (cur != -1) begin
                        lv.push_back(cur); tk.push_back(cnt);
                    end
                    cur = lit();
                    cnt = 0;
                    if (cur == 1) lit_starts++;
                end
                if (code_ready) ready_hi++;
                if (!busy) busy_lo++;
                if (inject_flash > 0 && lit_starts == inject_flash) begin
                    code_valid = 1'b1;
                    code_in = 4'd7;
                end else begin
                    code_valid = 1'b0;
                end
                if (tick_en) cnt++;
                clocks++;
            end
        end
        code_valid = 1'b0;
        if (cur != -1) begin
            lv.push_back(cur); tk.push_back(cnt);
        end
        check({tag, " done_seen"}, int'(got_done), 1);
        check({tag, " ready_low_in_frame"}, ready_hi, 0);
        check({tag, " busy_in_frame"}, busy_lo, 0);
        check({tag, " ready_at_done"}, int'(code_ready), 1);
        check({tag, " busy_at_done"}, int'(busy), 0);
        step();
        check({tag, " done_one_clock"}, int'(done), 0);
        model(code);
        check({tag, " seg_count"}, lv.size(), exp_lv.size());
        for (int i = 0; i < lv.size() && i < exp_lv.size(); i++) begin
            check($sformatf("%s seg%0d_level", tag, i), lv[i], exp_lv[i]);
            check($sformatf("%s seg%0d_ticks", tag, i), tk[i], exp_tk[i]);
        end
        foreach (lv[i]) if (lv[i] == 1) flashes++;
    endtask
`endif

    initial begin
        vec_t vecs[7];
        int fl;
        int ck;
        int c;
        int n_done;
        rst_n = 1'b0;
        tick_en = 1'b0;
        code_valid = 1'b0;
        code_in = 4'd0;
        repeat (3) step();
        check("reset led", lit(), 0);
        check("reset ready", int'(code_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        rst_n = 1'b1;
        step();

`ifndef WF_BLINK_REPEAT_EN
        vecs[0] = '{3, 0, 3, 0};
        vecs[1] = '{0, 0, 1, 0};
        vecs[2] = '{15, 0, 15, 0};
        vecs[3] = '{2, 1, 2, 10};
        vecs[4] = '{1, 1, 1, 6};
        vecs[5] = '{0, 1, 1, 10};
        vecs[6] = '{15, 1, 15, 62};
        foreach (vecs[i]) begin
            tick_mode = vecs[i].mode;
            run_frame($sformatf("vec%0d", i), vecs[i].code, 0, fl, ck);
            check($sformatf("vec%0d flashes", i), fl, vecs[i].exp_flashes);
            if (vecs[i].exp_clocks != 0)
                check($sformatf("vec%0d clocks", i), ck, vecs[i].exp_clocks);
        end

        // Offer while busy: code 7 during the 2nd flash of code 5 is dropped.
        tick_mode = 0;
        run_frame("busy_offer", 5, 2, fl, ck);
        check("busy_offer flashes", fl, 5);

        // Reset mid-flash aborts with no done.
        step();
        code_valid = 1'b1;
        code_in = 4'd3;
        step();
        code_valid = 1'b0;
        repeat (3) step();
        check("abort lit_before", lit(), 1);
        rst_n = 1'b0;
        step();
        check("abort led", lit(), 0);
        check("abort ready", int'(code_ready), 1);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || lit() == 1) n_done++;
        end
        check("abort quiet_after", n_done, 0);
        run_frame("after_abort", 1, 0, fl, ck);

        tick_mode = 2;
        for (int r = 0; r < 10; r++) begin
            c = $urandom_range(0, 15);
            run_frame($sformatf("rand%0d_code%0d", r, c), c, 0, fl, ck);
            check($sformatf("rand%0d flashes", r), fl, (c == 0) ? 1 : c);
        end
`else
        // Replay: code 2, then code 4 offered in the first gap takes over from frame 2.
        begin
            int frames[$];
            int cur_fl;
            int prev;
            int ready_lit;
            bit offered;
            int exp_fr[4];
            exp_fr = '{2, 4, 4, 4};
            tick_mode = 0;
            step();
            check("rep ready_idle", int'(code_ready), 1);
            code_valid = 1'b1;
            code_in = 4'd2;
            step();
            code_valid = 1'b0;
            cur_fl = 0; prev = 0; ready_lit = 0; offered = 1'b0;
            for (int cyc = 0; cyc < 5000 && frames.size() < 4; cyc++) begin
                if (cyc > 0) step();
                code_valid = 1'b0;
                if (done) begin
                    frames.push_back(cur_fl);
                    cur_fl = 0;
                end
                if (lit() == 1 && prev == 0) cur_fl++;
                if (lit() == 1 && code_ready) ready_lit++;
                if (!offered && cur_fl == 2 && lit() == 0 && code_ready) begin
                    code_valid = 1'b1;
                    code_in = 4'd4;
                    offered = 1'b1;
                end
                prev = lit();
            end
            code_valid = 1'b0;
            check("rep offered", int'(offered), 1);
            check("rep frames", frames.size(), 4);
            check("rep ready_not_lit", ready_lit, 0);
            check("rep busy", int'(busy), 1);
            foreach (frames[i]) if (i < 4) check($sformatf("rep frame%0d", i), frames[i], exp_fr[i]);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
